// File: rtl/vend_sequencer_if.sv
// vend_sequencer_if: coin, dispenser and hopper signals of the vending transaction controller
interface vend_sequencer_if #(parameter int CW = 6);
  logic coin_valid;
  logic [3:0] coin;
  logic cancel;
  logic vend_ack;
  logic chg_ack;
  logic vend_req;
  logic chg_req;
  logic [1:0] chg_type;
  logic coin_reject;
  logic [CW-1:0] credit;
  logic busy;
  modport slave (
    input coin_valid, coin, cancel, vend_ack, chg_ack,
    output vend_req, chg_req, chg_type, coin_reject, credit, busy
  );
  modport master (
    output coin_valid, coin, cancel, vend_ack, chg_ack,
    input vend_req, chg_req, chg_type, coin_reject, credit, busy
  );
endinterface

// File: rtl/vend_sequencer.sv
// vend_sequencer: accumulates coin credit, sequences the dispenser, then pays change greedily
module vend_sequencer #(
  parameter int PRICE = 15,
  parameter int MAX_CREDIT = 40,
  parameter int TIMEOUT_CYC = 500000000,
  parameter int CW = 6
) (
  input logic CLK50M,
  input logic RSTb,
  vend_sequencer_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, CREDIT, VEND, CHANGE_REQ, CHANGE_GAP} state_t;
  state_t state;
  logic [TW-1:0] cnt;
  logic [CW:0] val, sum;
  logic [CW-1:0] ncred, cval;
  logic onehot, open, tmo, cxl, acc;
  function automatic logic [1:0] pick(input logic [CW-1:0] c);
    return c >= CW'(5) ? 2'd2 : c >= CW'(2) ? 2'd1 : 2'd0;
  endfunction
  always_comb begin
    onehot = bus.coin inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
    val = bus.coin == 4'b0001 ? (CW+1)'(1) : bus.coin == 4'b0010 ? (CW+1)'(2) :
          bus.coin == 4'b0100 ? (CW+1)'(5) : bus.coin == 4'b1000 ? (CW+1)'(20) : '0;
    sum = {1'b0, bus.credit} + val;
    open = state == IDLE || state == CREDIT;
    tmo = state == CREDIT && cnt == TW'(TIMEOUT_CYC - 1);
    cxl = state == CREDIT && bus.cancel;
    // a coin arriving together with cancel or timeout loses; it is refused so the refund is exact
    acc = bus.coin_valid && open && onehot && sum <= (CW+1)'(MAX_CREDIT) && !cxl && !tmo;
    ncred = acc ? sum[CW-1:0] : bus.credit;
    cval = bus.chg_type == 2'd2 ? CW'(5) : bus.chg_type == 2'd1 ? CW'(2) : CW'(1);
  end
  always_ff @(posedge CLK50M or negedge RSTb) begin
    if (!RSTb) begin
      state <= IDLE;
      cnt <= '0;
      bus.credit <= '0;
      bus.vend_req <= 1'b0;
      bus.chg_req <= 1'b0;
      bus.chg_type <= 2'd0;
      bus.coin_reject <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.coin_reject <= bus.coin_valid && !acc;
      case (state)
        IDLE: if (acc) begin
          bus.credit <= ncred;
          cnt <= '0;
          state <= CREDIT;
        end
        CREDIT: if (cxl || tmo) begin
          state <= CHANGE_REQ;
          bus.chg_req <= 1'b1;
          bus.chg_type <= pick(bus.credit);
          bus.busy <= 1'b1;
        end else begin
          bus.credit <= ncred;
          cnt <= acc ? '0 : cnt + 1'b1;
          if (ncred >= CW'(PRICE)) begin
            state <= VEND;
            bus.vend_req <= 1'b1;
            bus.busy <= 1'b1;
          end
        end
        VEND: if (bus.vend_ack) begin
          bus.vend_req <= 1'b0;
          bus.credit <= bus.credit - CW'(PRICE);
          state <= bus.credit != CW'(PRICE) ? CHANGE_GAP : IDLE;
          bus.busy <= bus.credit != CW'(PRICE);
        end
        CHANGE_REQ: if (bus.chg_ack) begin
          bus.chg_req <= 1'b0;
          bus.credit <= bus.credit - cval;
          state <= CHANGE_GAP;
        end
        CHANGE_GAP: if (bus.credit != '0) begin
          state <= CHANGE_REQ;
          bus.chg_req <= 1'b1;
          bus.chg_type <= pick(bus.credit);
        end else begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed steps with a change-coin scoreboard on two price configurations
module tb_vend_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int exp_q[$];
  always #5 clk = ~clk;
  vend_sequencer_if #(.CW(6)) ia ();
  vend_sequencer_if #(.CW(6)) ib ();
  vend_sequencer #(.PRICE(15), .MAX_CREDIT(40), .TIMEOUT_CYC(100), .CW(6))
    dut_a (.CLK50M(clk), .RSTb(rst_n), .bus(ia));
  vend_sequencer #(.PRICE(30), .MAX_CREDIT(40), .TIMEOUT_CYC(100), .CW(6))
    dut_b (.CLK50M(clk), .RSTb(rst_n), .bus(ib));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic put_coin(input bit sel, input logic [3:0] c);
    if (sel) begin ib.coin = c; ib.coin_valid = 1'b1; end
    else begin ia.coin = c; ia.coin_valid = 1'b1; end
    tick();
    ia.coin_valid = 1'b0; ia.coin = 4'd0;
    ib.coin_valid = 1'b0; ib.coin = 4'd0;
  endtask
  task automatic serve_vend(input bit sel);
    int n = 0;
    while (!(sel ? ib.vend_req : ia.vend_req) && n < 200) begin tick(); n++; end
    chk("vend_wait", {31'd0, sel ? ib.vend_req : ia.vend_req}, 32'd1);
    if (sel) ib.vend_ack = 1'b1; else ia.vend_ack = 1'b1;
    tick();
    ia.vend_ack = 1'b0; ib.vend_ack = 1'b0;
    chk("vend_drop", {31'd0, sel ? ib.vend_req : ia.vend_req}, 32'd0);
  endtask
  task automatic serve_change();
    int n = 0;
    int e;
    while (!ia.chg_req && n < 200) begin tick(); n++; end
    chk("chg_wait", {31'd0, ia.chg_req}, 32'd1);
    chk("q_empty", {31'd0, exp_q.size() == 0}, 32'd0);
    e = exp_q.size() != 0 ? exp_q.pop_front() : -1;
    chk("chg_type", {30'd0, ia.chg_type}, e);
    ia.chg_ack = 1'b1;
    tick();
    ia.chg_ack = 1'b0;
    chk("chg_drop", {31'd0, ia.chg_req}, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
  initial begin
    ia.coin_valid = 1'b0; ia.coin = 4'd0; ia.cancel = 1'b0; ia.vend_ack = 1'b0; ia.chg_ack = 1'b0;
    ib.coin_valid = 1'b0; ib.coin = 4'd0; ib.cancel = 1'b0; ib.vend_ack = 1'b0; ib.chg_ack = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_credit", {26'd0, ia.credit}, 32'd0);
    chk("rst_busy", {31'd0, ia.busy}, 32'd0);
    put_coin(0, 4'b0010);
    put_coin(0, 4'b0010);
    ia.cancel = 1'b1;
    tick();
    ia.cancel = 1'b0;
    chk("pre_rst_req", {31'd0, ia.chg_req}, 32'd1);
    chk("pre_rst_credit", {26'd0, ia.credit}, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_chg_req", {31'd0, ia.chg_req}, 32'd0);
    chk("async_credit", {26'd0, ia.credit}, 32'd0);
    chk("async_busy", {31'd0, ia.busy}, 32'd0);
    chk("async_type", {30'd0, ia.chg_type}, 32'd0);
    chk("async_vend", {31'd0, ia.vend_req}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_chg", {31'd0, ia.chg_req}, 32'd0);
    chk("post_rst_vend", {31'd0, ia.vend_req}, 32'd0);
    put_coin(0, 4'b0100);
    chk("q1_credit", {26'd0, ia.credit}, 32'd5);
    repeat (5) tick();
    put_coin(0, 4'b0100);
    chk("q2_credit", {26'd0, ia.credit}, 32'd10);
    chk("q2_vend", {31'd0, ia.vend_req}, 32'd0);
    repeat (5) tick();
    put_coin(0, 4'b0100);
    chk("q3_credit", {26'd0, ia.credit}, 32'd15);
    chk("q3_vend", {31'd0, ia.vend_req}, 32'd1);
    chk("q3_busy", {31'd0, ia.busy}, 32'd1);
    put_coin(0, 4'b0001);
    chk("vend_coin_rej", {31'd0, ia.coin_reject}, 32'd1);
    chk("vend_coin_credit", {26'd0, ia.credit}, 32'd15);
    tick();
    chk("vend_rej_pulse", {31'd0, ia.coin_reject}, 32'd0);
    ia.cancel = 1'b1;
    repeat (2) tick();
    ia.cancel = 1'b0;
    chk("vend_hold", {31'd0, ia.vend_req}, 32'd1);
    ia.vend_ack = 1'b1;
    tick();
    chk("vq_credit", {26'd0, ia.credit}, 32'd0);
    chk("vq_vend", {31'd0, ia.vend_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("vq_no_chg", {31'd0, ia.chg_req}, 32'd0);
    end
    ia.vend_ack = 1'b0;
    chk("vq_idle", {31'd0, ia.busy}, 32'd0);
    put_coin(0, 4'b1000);
    chk("dollar_credit", {26'd0, ia.credit}, 32'd20);
    exp_q.push_back(2);
    serve_vend(0);
    chk("dollar_rem", {26'd0, ia.credit}, 32'd5);
    serve_change();
    chk("dollar_chg_credit", {26'd0, ia.credit}, 32'd0);
    tick();
    chk("dollar_idle", {31'd0, ia.busy}, 32'd0);
    ia.chg_ack = 1'b1; ia.vend_ack = 1'b1;
    tick();
    ia.chg_ack = 1'b0; ia.vend_ack = 1'b0;
    chk("stray_ack", {26'd0, ia.credit}, 32'd0);
    put_coin(0, 4'b0010);
    put_coin(0, 4'b0010);
    exp_q.push_back(1);
    exp_q.push_back(1);
    ia.cancel = 1'b1; ia.coin = 4'b0001; ia.coin_valid = 1'b1;
    tick();
    ia.cancel = 1'b0; ia.coin = 4'd0; ia.coin_valid = 1'b0;
    chk("cxl_coin_rej", {31'd0, ia.coin_reject}, 32'd1);
    chk("cxl_credit", {26'd0, ia.credit}, 32'd4);
    serve_change();
    chk("cxl_mid_credit", {26'd0, ia.credit}, 32'd2);
    tick();
    chk("cxl_gap_end", {31'd0, ia.chg_req}, 32'd1);
    serve_change();
    tick();
    chk("cxl_done", {26'd0, ia.credit}, 32'd0);
    chk("cxl_idle", {31'd0, ia.busy}, 32'd0);
    put_coin(0, 4'b0110);
    chk("bad_coin_rej", {31'd0, ia.coin_reject}, 32'd1);
    chk("bad_coin_credit", {26'd0, ia.credit}, 32'd0);
    tick();
    chk("bad_coin_pulse", {31'd0, ia.coin_reject}, 32'd0);
    chk("bad_coin_idle", {31'd0, ia.busy}, 32'd0);
    put_coin(1, 4'b1000);
    put_coin(1, 4'b0100);
    chk("b_credit25", {26'd0, ib.credit}, 32'd25);
    put_coin(1, 4'b1000);
    chk("b_over_rej", {31'd0, ib.coin_reject}, 32'd1);
    chk("b_over_credit", {26'd0, ib.credit}, 32'd25);
    tick();
    chk("b_over_pulse", {31'd0, ib.coin_reject}, 32'd0);
    chk("b_no_vend", {31'd0, ib.vend_req}, 32'd0);
    put_coin(1, 4'b0100);
    chk("b_vend", {31'd0, ib.vend_req}, 32'd1);
    serve_vend(1);
    chk("b_done", {26'd0, ib.credit}, 32'd0);
    put_coin(0, 4'b0001);
    repeat (99) tick();
    chk("tmo_early", {31'd0, ia.chg_req}, 32'd0);
    exp_q.push_back(0);
    tick();
    chk("tmo_fire", {31'd0, ia.chg_req}, 32'd1);
    serve_change();
    tick();
    chk("tmo_idle", {31'd0, ia.busy}, 32'd0);
    put_coin(0, 4'b0001);
    repeat (98) tick();
    put_coin(0, 4'b0001);
    chk("tmo_restart_credit", {26'd0, ia.credit}, 32'd2);
    tick();
    chk("tmo_restart_100", {31'd0, ia.chg_req}, 32'd0);
    repeat (98) tick();
    chk("tmo_restart_early", {31'd0, ia.chg_req}, 32'd0);
    exp_q.push_back(1);
    tick();
    chk("tmo_restart_fire", {31'd0, ia.chg_req}, 32'd1);
    serve_change();
    tick();
    chk("tmo2_done", {26'd0, ia.credit}, 32'd0);
    chk("q_drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
